sd_wr_sector_feeder: RTL and testbench
======================================

SD_WR_SECTOR_FEEDER -- requirements
Module: sd_wr_sector_feeder

Interface
REQ-001 SECTOR_WORDS, 256, 16-bit words per sector (one 512-byte block).
REQ-002 clk_sd  input  1  sole clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 sd_init_done  input  1  card initialised; no byte is accepted while low.
REQ-005 addr_load  input  1  one-cycle pulse that loads start_sec_addr into the sector address.
REQ-006 start_sec_addr  input  32  first sector to write.
REQ-007 s_valid  input  1  upstream byte valid.
REQ-008 s_data  input  8  upstream byte.
REQ-009 s_ready  output  1  byte accepted when s_valid and s_ready are both high.
REQ-010 flush  input  1  one-cycle pulse: zero-pad the partial sector and write it.
REQ-011 wr_start_en  output  1  one-cycle pulse to the SD write engine.
REQ-012 wr_sec_addr  output  32  sector address; stable from the wr_start_en pulse until wr_busy falls.
REQ-013 wr_busy  input  1  write engine busy.
REQ-014 wr_req  input  1  write engine requests the next word.
REQ-015 wr_data  output  16  word presented to the write engine.
REQ-016 sec_done  output  1  one-cycle pulse when a sector write completes.
REQ-017 err  output  1  sticky protocol-error flag.

Function
REQ-018 The module SHALL pack bytes in big-endian order: the first byte goes to wr_data[15:8], the second to [7:0].
REQ-019 The module SHALL store words in a SECTOR_WORDS x 16 buffer with a 9-bit write counter (wcnt) and a 9-bit read counter (rcnt).
REQ-020 FSM states SHALL be FILL, START, WAIT_BUSY, XFER, WAIT_DONE.
REQ-021 FILL: s_ready = sd_init_done; on the handshake the byte is packed; when wcnt reaches SECTOR_WORDS the FSM goes to START.
REQ-022 START: wr_start_en SHALL be high for exactly one cycle, then the FSM goes to WAIT_BUSY.
REQ-023 WAIT_BUSY: the FSM SHALL go to XFER on the first cycle wr_busy is high.
REQ-024 XFER: wr_data SHALL equal buffer[rcnt] in every cycle wr_req is high; rcnt increments on the following edge.
REQ-025 XFER: when wr_busy falls the FSM SHALL go to WAIT_DONE.
REQ-026 WAIT_DONE (one cycle): the module SHALL pulse sec_done, increment wr_sec_addr by 1 (32-bit wrap-around), clear wcnt, rcnt and the byte phase, then return to FILL.
REQ-027 s_ready SHALL be 0 in every state except FILL.
REQ-028 Flush in FILL with wcnt > 0 or a pending high byte: the module SHALL store the pending byte with low byte 00, fill the remaining words with 0000, and then go to START.
REQ-029 Flush with an empty buffer and no pending byte SHALL be ignored; flush outside FILL SHALL be ignored.
REQ-030 If s_valid handshake and flush occur in the same cycle, the byte SHALL be accepted first and the padding SHALL follow it.
REQ-031 Padding SHALL write one word per cycle; s_ready SHALL be 0 during padding.
REQ-032 addr_load SHALL take effect only in FILL with wcnt = 0 and no pending byte; otherwise it is ignored and err is set.
REQ-033 A wr_req beyond SECTOR_WORDS in one sector SHALL set err; rcnt saturates and wr_data holds its last value.
REQ-034 wr_req outside XFER SHALL set err and SHALL be ignored.
REQ-035 err SHALL clear only on reset.

Reset
REQ-036 On reset the FSM SHALL enter FILL with wcnt, rcnt and the byte phase cleared.
REQ-037 On reset: s_ready=0, wr_start_en=0, wr_sec_addr=0, wr_data=0000, sec_done=0, err=0; buffer contents are don't-care.
REQ-038 Reset asserted mid-XFER SHALL abort the current sector with no sec_done pulse.

Structure
REQ-039 A shared package SHALL hold the FSM state enum, SECTOR_WORDS and the counter width.
REQ-040 The buffer SHALL be a separate sub-module, sd_sector_ram (simple dual-port, one write port and one registered read port); the read address is prefetched so that REQ-024 holds.

Verification
REQ-041 Load 0x00000010, stream 512 bytes 00..FF,00..FF -> one wr_start_en, wr_sec_addr=0x10, words 0001,0203,...,FEFF, then sec_done.
REQ-042 Stream 1024 bytes -> two sectors at 0x10 and 0x11; s_ready=0 from START until WAIT_DONE.
REQ-043 Stream 3 bytes AA,BB,CC then flush -> words AABB, CC00, then 254 x 0000.
REQ-044 Flush together with byte 0x55 as the first byte -> word 5500 followed by 255 x 0000; flush on an empty buffer -> no wr_start_en.
REQ-045 Issue 257 wr_req pulses -> err=1 and wr_data stays at word 255; a stray wr_req in FILL -> err=1.
REQ-046 Assert reset at wr_req #100 -> all outputs at reset values, no sec_done; the next sector restarts at word 0.

Source files
------------

// File: rtl/sd_wr_sector_feeder_pkg.sv
// Shared types and sizing for the SD write sector feeder.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sd_wr_sector_feeder_pkg;
  localparam int SECTOR_WORDS = 256;  // 16-bit words per 512-byte block
  localparam int CNT_W        = 9;    // counts 0..SECTOR_WORDS inclusive
  localparam int ADDR_W       = 8;    // buffer word address

  typedef enum logic [2:0] {
    FILL,
    START,
    WAIT_BUSY,
    XFER,
    WAIT_DONE
  } state_t;
endpackage

// File: rtl/sd_wr_sector_feeder_ram.sv
// One-sector word buffer: one write port, one registered read port.
// Latency: read data appears one clock after raddr is presented with re high.
// Backpressure: none; rdata holds its value while re is low.
module sd_sector_ram
  import sd_wr_sector_feeder_pkg::*;
(
  input  logic              clk_sd,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);
  logic [15:0] mem [SECTOR_WORDS];

  // Write port; contents are not reset.
  always_ff @(posedge clk_sd) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; clears on reset so the engine sees 0000.
  always_ff @(posedge clk_sd) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sd_wr_sector_feeder.sv
// Packs an upstream byte stream into 512-byte sectors and feeds them to an SD write engine.
// Latency: a sector is offered (wr_start_en) one clock after its last word is written.
// Backpressure: s_ready drops outside FILL and during zero-padding; the engine paces words via wr_req.
module sd_wr_sector_feeder
  import sd_wr_sector_feeder_pkg::*;
(
  input  logic        clk_sd,
  input  logic        reset,
  input  logic        sd_init_done,
  input  logic        addr_load,
  input  logic [31:0] start_sec_addr,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  input  logic        flush,
  output logic        wr_start_en,
  output logic [31:0] wr_sec_addr,
  input  logic        wr_busy,
  input  logic        wr_req,
  output logic [15:0] wr_data,
  output logic        sec_done,
  output logic        err
);
  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wcnt, wcnt_nxt, rcnt, rcnt_nxt;
  logic              phase, phase_nxt;   // high byte held, waiting for low byte
  logic              pad, pad_nxt;       // zero-padding the rest of the sector
  logic [7:0]        hi_byte, hi_byte_nxt;
  logic [31:0]       addr_nxt;
  logic              err_nxt;
  logic              ram_we;
  logic [15:0]       ram_wdata;
  logic              hs, empty, last_word;

  // Read address is the next rcnt so the registered RAM output equals buffer[rcnt].
  sd_sector_ram u_ram (
    .clk_sd (clk_sd),
    .reset  (reset),
    .we     (ram_we),
    .waddr  (wcnt[ADDR_W-1:0]),
    .wdata  (ram_wdata),
    .re     (!rcnt_nxt[CNT_W-1]),
    .raddr  (rcnt_nxt[ADDR_W-1:0]),
    .rdata  (wr_data)
  );

  // Next-state, buffer writes, counters and pulse outputs.
  always_comb begin
    state_nxt   = state;
    wcnt_nxt    = wcnt;
    rcnt_nxt    = rcnt;
    phase_nxt   = phase;
    pad_nxt     = pad;
    hi_byte_nxt = hi_byte;
    addr_nxt    = wr_sec_addr;
    err_nxt     = err;
    ram_we      = 1'b0;
    ram_wdata   = '0;
    s_ready     = 1'b0;
    wr_start_en = 1'b0;
    sec_done    = 1'b0;
    hs          = 1'b0;
    empty       = (wcnt == '0) && !phase;
    last_word   = (wcnt == CNT_W'(SECTOR_WORDS - 1));

    // Address may only change between sectors, before any byte arrives.
    if (addr_load) begin
      if (state == FILL && empty) addr_nxt = start_sec_addr;
      else                        err_nxt  = 1'b1;
    end
    if (wr_req && state != XFER) err_nxt = 1'b1;

    case (state)
      FILL: begin
        s_ready = sd_init_done && !pad && !reset;
        hs      = s_valid && s_ready;
        if (pad) begin
          // First pad word carries a pending high byte, the rest are zero.
          ram_we    = 1'b1;
          ram_wdata = phase ? {hi_byte, 8'h00} : 16'h0000;
          phase_nxt = 1'b0;
          wcnt_nxt  = wcnt + CNT_W'(1);
          if (last_word) begin
            pad_nxt   = 1'b0;
            state_nxt = START;
          end
        end else begin
          if (hs) begin
            if (phase) begin
              ram_we    = 1'b1;
              ram_wdata = {hi_byte, s_data};
              phase_nxt = 1'b0;
              wcnt_nxt  = wcnt + CNT_W'(1);
              if (last_word) state_nxt = START;
            end else begin
              hi_byte_nxt = s_data;
              phase_nxt   = 1'b1;
            end
          end
          // A flush alongside a byte pads after that byte; a full sector needs no pad.
          if (flush && (hs || !empty) && !(ram_we && last_word)) pad_nxt = 1'b1;
        end
      end
      START: begin
        wr_start_en = 1'b1;
        state_nxt   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (wr_busy) state_nxt = XFER;
      end
      XFER: begin
        if (wr_req) begin
          if (!rcnt[CNT_W-1]) rcnt_nxt = rcnt + CNT_W'(1);
          else                err_nxt  = 1'b1;
        end
        if (!wr_busy) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        sec_done  = 1'b1;
        addr_nxt  = wr_sec_addr + 32'd1;
        wcnt_nxt  = '0;
        rcnt_nxt  = '0;
        phase_nxt = 1'b0;
        pad_nxt   = 1'b0;
        state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase

    if (reset) rcnt_nxt = '0;
  end

  // State and datapath registers.
  always_ff @(posedge clk_sd) begin
    if (reset) begin
      state       <= FILL;
      wcnt        <= '0;
      rcnt        <= '0;
      phase       <= 1'b0;
      pad         <= 1'b0;
      hi_byte     <= '0;
      wr_sec_addr <= '0;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      wcnt        <= wcnt_nxt;
      rcnt        <= rcnt_nxt;
      phase       <= phase_nxt;
      pad         <= pad_nxt;
      hi_byte     <= hi_byte_nxt;
      wr_sec_addr <= addr_nxt;
      err         <= err_nxt;
    end
  end
endmodule

// File: tb/tb_sd_wr_sector_feeder.sv
// Self-checking bench for sd_wr_sector_feeder with a behavioural SD write engine.
// Latency: n/a.
// Backpressure: sender honours s_ready; engine paces words with random wr_req gaps.
module tb_sd_wr_sector_feeder;
  import sd_wr_sector_feeder_pkg::*;

  logic        clk_sd = 1'b0;
  logic        reset, sd_init_done, addr_load, s_valid, s_ready, flush;
  logic [31:0] start_sec_addr, wr_sec_addr;
  logic [7:0]  s_data;
  logic        wr_start_en, wr_busy, wr_req, sec_done, err;
  logic [15:0] wr_data;

  int checks = 0, errors = 0;
  int start_cnt = 0, done_cnt = 0, sready_viol = 0, tmo_cnt = 0;
  bit in_sector = 0;
  logic [15:0] got_q[$];
  logic [31:0] got_addr, exp_addr;
  logic [15:0] exp_w [SECTOR_WORDS];
  int first_bad;

  sd_wr_sector_feeder dut (
    .clk_sd(clk_sd), .reset(reset), .sd_init_done(sd_init_done), .addr_load(addr_load),
    .start_sec_addr(start_sec_addr), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .flush(flush), .wr_start_en(wr_start_en), .wr_sec_addr(wr_sec_addr), .wr_busy(wr_busy),
    .wr_req(wr_req), .wr_data(wr_data), .sec_done(sec_done), .err(err)
  );

  always #5 clk_sd = ~clk_sd;

  // Event monitor: pulse counts and s_ready while a sector is in flight.
  always @(negedge clk_sd) begin
    if (wr_start_en === 1'b1) begin start_cnt++; in_sector = 1; end
    if (in_sector && s_ready === 1'b1) sready_viol++;
    if (sec_done === 1'b1) done_cnt++;
    if (sec_done === 1'b1 || reset === 1'b1) in_sector = 0;
  end

  // Reference: sector = bytes from base, paired big-endian, zero-filled past the end.
  function automatic void model_sector(input logic [7:0] b[$], input int base);
    for (int i = 0; i < SECTOR_WORDS; i++) begin
      logic [7:0] hi, lo;
      hi = (base + 2*i     < b.size()) ? b[base + 2*i]     : 8'h00;
      lo = (base + 2*i + 1 < b.size()) ? b[base + 2*i + 1] : 8'h00;
      exp_w[i] = {hi, lo};
    end
  endfunction

  function automatic int sector_diffs();
    int n = 0;
    first_bad = -1;
    if (got_q.size() < SECTOR_WORDS) return SECTOR_WORDS;
    for (int i = 0; i < SECTOR_WORDS; i++)
      if (got_q[i] !== exp_w[i]) begin
        if (first_bad < 0) first_bad = i;
        n++;
      end
    return n;
  endfunction

  task automatic do_reset();
    reset = 1; s_valid = 0; flush = 0; addr_load = 0; wr_req = 0; wr_busy = 0;
    repeat (3) @(negedge clk_sd);
    reset = 0;
    @(negedge clk_sd);
  endtask

  task automatic load_addr(input logic [31:0] a);
    addr_load = 1; start_sec_addr = a;
    @(negedge clk_sd);
    addr_load = 0;
  endtask

  task automatic pulse_flush();
    flush = 1;
    @(negedge clk_sd);
    flush = 0;
  endtask

  task automatic send_bytes(input logic [7:0] q[$], input bit flush_last);
    int t;
    for (int i = 0; i < q.size(); i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk_sd);
      s_valid = 1; s_data = q[i]; t = 0;
      while (s_ready !== 1'b1 && t < 4000) begin @(negedge clk_sd); t++; end
      if (t >= 4000) tmo_cnt++;
      if (flush_last && i == q.size() - 1) flush = 1;
      @(negedge clk_sd);
      s_valid = 0; flush = 0;
    end
  endtask

  // Behavioural write engine: collects the words it is handed into got_q.
  task automatic serve_sector(input int n_req, input bit abort);
    int t;
    got_q.delete();
    t = 0;
    while (wr_start_en !== 1'b1 && t < 4000) begin @(negedge clk_sd); t++; end
    if (t >= 4000) begin tmo_cnt++; return; end
    got_addr = wr_sec_addr;
    repeat ($urandom_range(0, 2)) @(negedge clk_sd);
    wr_busy = 1;
    repeat (2) @(negedge clk_sd);
    for (int i = 0; i < n_req; i++) begin
      if ($urandom_range(0, 2) == 0) begin wr_req = 0; @(negedge clk_sd); end
      wr_req = 1;
      got_q.push_back(wr_data);
      if (abort && i == n_req - 1) reset = 1;
      @(negedge clk_sd);
    end
    wr_req = 0; wr_busy = 0;
    if (!abort) begin
      t = 0;
      while (sec_done !== 1'b1 && t < 10) begin @(negedge clk_sd); t++; end
      if (t >= 10) tmo_cnt++;
      @(negedge clk_sd);
    end
  endtask

  task automatic test_reset();
    reset = 1; sd_init_done = 1; addr_load = 0; start_sec_addr = 0; s_valid = 0;
    s_data = 0; flush = 0; wr_busy = 0; wr_req = 0;
    repeat (3) @(negedge clk_sd);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    checks++; if (wr_start_en !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", wr_start_en); end
    checks++; if (wr_sec_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", wr_sec_addr); end
    checks++; if (wr_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", wr_data); end
    checks++; if (sec_done !== 1'b0) begin errors++; $display("FAIL reset_sec_done: got %b want 0", sec_done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    reset = 0;
    @(negedge clk_sd);
    sd_init_done = 0; #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL init_low_ready: got %b want 0", s_ready); end
    sd_init_done = 1; #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL init_high_ready: got %b want 1", s_ready); end
    @(negedge clk_sd);
    exp_addr = 0;
  endtask

  task automatic test_full_sector();
    logic [7:0] b[$];
    int s0, d0;
    load_addr(32'h10); exp_addr = 32'h10;
    for (int i = 0; i < 512; i++) b.push_back(8'(i));
    s0 = start_cnt; d0 = done_cnt;
    fork
      send_bytes(b, 0);
      serve_sector(SECTOR_WORDS, 0);
    join
    model_sector(b, 0);
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL full_starts: got %0d want 1", start_cnt - s0); end
    checks++; if (got_addr !== exp_addr) begin errors++; $display("FAIL full_addr: got %h want %h", got_addr, exp_addr); end
    checks++; if (sector_diffs() !== 0) begin errors++; $display("FAIL full_data: got %0d bad words (first %0d) want 0", sector_diffs(), first_bad); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL full_done: got %0d want 1", done_cnt - d0); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL full_err: got %b want 0", err); end
    exp_addr = exp_addr + 1;
    checks++; if (wr_sec_addr !== exp_addr) begin errors++; $display("FAIL full_addr_inc: got %h want %h", wr_sec_addr, exp_addr); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[$];
    int s0, d0, v0;
    load_addr(32'h10); exp_addr = 32'h10;
    for (int i = 0; i < 1024; i++) b.push_back(8'($urandom));
    s0 = start_cnt; d0 = done_cnt; v0 = sready_viol;
    fork
      send_bytes(b, 0);
      begin
        serve_sector(SECTOR_WORDS, 0);
        model_sector(b, 0);
        checks++; if (got_addr !== 32'h10) begin errors++; $display("FAIL b2b_addr0: got %h want 00000010", got_addr); end
        checks++; if (sector_diffs() !== 0) begin errors++; $display("FAIL b2b_data0: got %0d bad words (first %0d) want 0", sector_diffs(), first_bad); end
        serve_sector(SECTOR_WORDS, 0);
        model_sector(b, 512);
        checks++; if (got_addr !== 32'h11) begin errors++; $display("FAIL b2b_addr1: got %h want 00000011", got_addr); end
        checks++; if (sector_diffs() !== 0) begin errors++; $display("FAIL b2b_data1: got %0d bad words (first %0d) want 0", sector_diffs(), first_bad); end
      end
    join
    exp_addr = 32'h12;
    checks++; if (start_cnt - s0 !== 2) begin errors++; $display("FAIL b2b_starts: got %0d want 2", start_cnt - s0); end
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_done: got %0d want 2", done_cnt - d0); end
    checks++; if (sready_viol - v0 !== 0) begin errors++; $display("FAIL b2b_ready_busy: got %0d cycles want 0", sready_viol - v0); end
  endtask

  task automatic test_flush_partial();
    logic [7:0] b[$];
    int n;
    bit fl;
    b = {8'hAA, 8'hBB, 8'hCC};
    send_bytes(b, 0);
    pulse_flush();
    serve_sector(SECTOR_WORDS, 0);
    model_sector(b, 0);
    checks++; if (got_q[1] !== 16'hCC00) begin errors++; $display("FAIL flush3_word1: got %h want CC00", got_q[1]); end
    checks++; if (sector_diffs() !== 0) begin errors++; $display("FAIL flush3_data: got %0d bad words (first %0d) want 0", sector_diffs(), first_bad); end
    checks++; if (got_addr !== exp_addr) begin errors++; $display("FAIL flush3_addr: got %h want %h", got_addr, exp_addr); end
    exp_addr = exp_addr + 1;
    for (int trial = 0; trial < 3; trial++) begin
      b.delete();
      n = $urandom_range(1, 511);
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      fl = 1'($urandom_range(0, 1));
      send_bytes(b, fl);
      if (!fl) pulse_flush();
      serve_sector(SECTOR_WORDS, 0);
      model_sector(b, 0);
      checks++; if (sector_diffs() !== 0) begin errors++; $display("FAIL flush_rand%0d n=%0d: got %0d bad words (first %0d) want 0", trial, n, sector_diffs(), first_bad); end
      checks++; if (got_addr !== exp_addr) begin errors++; $display("FAIL flush_rand%0d_addr: got %h want %h", trial, got_addr, exp_addr); end
      exp_addr = exp_addr + 1;
    end
  endtask

  task automatic test_flush_with_byte();
    logic [7:0] b[$];
    int s0;
    b = {8'h55};
    send_bytes(b, 1);
    serve_sector(SECTOR_WORDS, 0);
    model_sector(b, 0);
    checks++; if (got_q[0] !== 16'h5500) begin errors++; $display("FAIL flushbyte_word0: got %h want 5500", got_q[0]); end
    checks++; if (sector_diffs() !== 0) begin errors++; $display("FAIL flushbyte_data: got %0d bad words (first %0d) want 0", sector_diffs(), first_bad); end
    exp_addr = exp_addr + 1;
    s0 = start_cnt;
    pulse_flush();
    repeat (300) @(negedge clk_sd);
    checks++; if (start_cnt !== s0) begin errors++; $display("FAIL flush_empty: got %0d starts want 0", start_cnt - s0); end
  endtask

  task automatic test_addr_load_busy();
    logic [7:0] b[$];
    do_reset(); exp_addr = 0;
    b = {8'h77};
    send_bytes(b, 0);
    load_addr(32'h99);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL load_nonempty_err: got %b want 1", err); end
    pulse_flush();
    serve_sector(SECTOR_WORDS, 0);
    checks++; if (got_addr !== 32'h0) begin errors++; $display("FAIL load_ignored_addr: got %h want 00000000", got_addr); end
    checks++; if (got_q[0] !== 16'h7700) begin errors++; $display("FAIL load_ignored_word0: got %h want 7700", got_q[0]); end
  endtask

  task automatic test_overrun();
    logic [7:0] b[$];
    do_reset(); exp_addr = 0;
    for (int i = 0; i < 512; i++) b.push_back(8'($urandom));
    fork
      send_bytes(b, 0);
      serve_sector(SECTOR_WORDS + 1, 0);
    join
    model_sector(b, 0);
    checks++; if (sector_diffs() !== 0) begin errors++; $display("FAIL overrun_data: got %0d bad words (first %0d) want 0", sector_diffs(), first_bad); end
    checks++; if (got_q[SECTOR_WORDS] !== exp_w[SECTOR_WORDS-1]) begin errors++; $display("FAIL overrun_hold: got %h want %h", got_q[SECTOR_WORDS], exp_w[SECTOR_WORDS-1]); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL overrun_err: got %b want 1", err); end
    do_reset();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear_on_reset: got %b want 0", err); end
    wr_req = 1;
    @(negedge clk_sd);
    wr_req = 0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL stray_req_err: got %b want 1", err); end
    do_reset();
  endtask

  task automatic test_reset_abort();
    logic [7:0] b[$];
    int d0;
    load_addr(32'h20);
    for (int i = 0; i < 512; i++) b.push_back(8'($urandom));
    fork
      send_bytes(b, 0);
      serve_sector(100, 1);
    join
    d0 = done_cnt;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL abort_s_ready: got %b want 0", s_ready); end
    checks++; if (wr_start_en !== 1'b0) begin errors++; $display("FAIL abort_start: got %b want 0", wr_start_en); end
    checks++; if (wr_sec_addr !== 32'h0) begin errors++; $display("FAIL abort_addr: got %h want 0", wr_sec_addr); end
    checks++; if (wr_data !== 16'h0) begin errors++; $display("FAIL abort_data: got %h want 0000", wr_data); end
    checks++; if (sec_done !== 1'b0) begin errors++; $display("FAIL abort_sec_done: got %b want 0", sec_done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_err: got %b want 0", err); end
    @(negedge clk_sd);
    reset = 0;
    repeat (20) @(negedge clk_sd);
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - d0); end
    b.delete();
    for (int i = 0; i < 512; i++) b.push_back(8'($urandom));
    fork
      send_bytes(b, 0);
      serve_sector(SECTOR_WORDS, 0);
    join
    model_sector(b, 0);
    checks++; if (got_addr !== 32'h0) begin errors++; $display("FAIL restart_addr: got %h want 00000000", got_addr); end
    checks++; if (sector_diffs() !== 0) begin errors++; $display("FAIL restart_data: got %0d bad words (first %0d) want 0", sector_diffs(), first_bad); end
  endtask

  initial begin
    test_reset();
    test_full_sector();
    test_back_to_back();
    test_flush_partial();
    test_flush_with_byte();
    test_addr_load_busy();
    test_overrun();
    test_reset_abort();
    checks++; if (tmo_cnt !== 0) begin errors++; $display("FAIL timeouts: got %0d want 0", tmo_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
